// File: rtl/control_unit_fsm_if.sv
// Control-word interface between the LEGv8 control unit (master) and the datapath (slave).
// Widths default to the fixed 30-bit control word and 64-bit constant.
interface control_unit_fsm_if #(
  parameter int CW_W   = 30,
  parameter int DATA_W = 64
);
  logic [31:0]       instruction;
  logic [4:0]        status;
  logic [CW_W-1:0]   control_word;
  logic [DATA_W-1:0] constant;
  logic              halted;
  logic [1:0]        state_dbg;

  // No valid/ready pair: control_word and constant are valid every cycle, the datapath
  // consumes them unconditionally, and there is no backpressure toward the control unit.
  modport master (
    input  instruction, status,
    output control_word, constant, halted, state_dbg
  );

  modport slave (
    output instruction, status,
    input  control_word, constant, halted, state_dbg
  );
endinterface

// File: rtl/control_unit_fsm.sv
// Multi-cycle LEGv8 control unit: FETCH / EXECUTE / MEM / HALT, decodes IR into the control word.
// Optional B.cond decode is enabled by defining CU_BCOND_EN.
module control_unit_fsm #(
  parameter int CW_W   = 30,
  parameter int DATA_W = 64
) (
  input  logic                clock,
  input  logic                reset,
  control_unit_fsm_if.master  cu
);

  typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_MEM = 2'd2, S_HALT = 2'd3} state_t;
  typedef enum logic [3:0] {
    K_NONE, K_RTYPE, K_ITYPE, K_STUR, K_LDUR, K_B, K_BL, K_BR, K_CBZ, K_CBNZ, K_BCOND
  } kind_t;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  kind_t       kind;
  logic [4:0]  alu_fs;
  logic        alu_sl;
  logic        bcond_taken;

  logic [4:0] rd, rn, rm;
  assign rd = ir_q[4:0];
  assign rn = ir_q[9:5];
  assign rm = ir_q[20:16];

  logic [DATA_W-1:0] imm12_z, imm9_s, imm19_s, imm26_s;
  assign imm12_z = {{(DATA_W-12){1'b0}}, ir_q[21:10]};
  assign imm9_s  = {{(DATA_W-9){ir_q[20]}}, ir_q[20:12]};
  assign imm19_s = {{(DATA_W-19){ir_q[23]}}, ir_q[23:5]};
  assign imm26_s = {{(DATA_W-26){ir_q[25]}}, ir_q[25:0]};

  // Longest prefix first: 11-bit opcodes, then 10, 8 and 6 bits.
  always_comb begin
    kind   = K_NONE;
    alu_fs = 5'b00000;
    alu_sl = 1'b0;
    case (ir_q[31:21])
      11'b10001011000: begin kind = K_RTYPE; alu_fs = 5'b01000; end
      11'b11001011000: begin kind = K_RTYPE; alu_fs = 5'b01001; end
      11'b10001010000: begin kind = K_RTYPE; alu_fs = 5'b00000; end
      11'b10101010000: begin kind = K_RTYPE; alu_fs = 5'b00100; end
      11'b11001010000: begin kind = K_RTYPE; alu_fs = 5'b01100; end
      11'b10101011000: begin kind = K_RTYPE; alu_fs = 5'b01000; alu_sl = 1'b1; end
      11'b11101011000: begin kind = K_RTYPE; alu_fs = 5'b01001; alu_sl = 1'b1; end
      11'b11111000000: kind = K_STUR;
      11'b11111000010: kind = K_LDUR;
      11'b11010110000: kind = K_BR;
      default: begin
        if (ir_q[31:22] == 10'b1001000100) begin
          kind = K_ITYPE; alu_fs = 5'b01000;
        end else if (ir_q[31:22] == 10'b1101000100) begin
          kind = K_ITYPE; alu_fs = 5'b01001;
        end else if (ir_q[31:24] == 8'b10110100) begin
          kind = K_CBZ;
        end else if (ir_q[31:24] == 8'b10110101) begin
          kind = K_CBNZ;
`ifdef CU_BCOND_EN
        end else if (ir_q[31:24] == 8'b01010100 && !ir_q[4]) begin
          kind = K_BCOND;
`endif
        end else if (ir_q[31:26] == 6'b000101) begin
          kind = K_B;
        end else if (ir_q[31:26] == 6'b100101) begin
          kind = K_BL;
        end
      end
    endcase
  end

`ifdef CU_BCOND_EN
  logic cond_base;
  // cond[3:1] picks the test, cond[0] inverts it, except 1111 which is always taken.
  always_comb begin
    case (ir_q[3:1])
      3'b000:  cond_base = cu.status[1];
      3'b001:  cond_base = cu.status[3];
      3'b010:  cond_base = cu.status[2];
      3'b011:  cond_base = cu.status[4];
      3'b100:  cond_base = cu.status[3] & ~cu.status[1];
      3'b101:  cond_base = (cu.status[2] == cu.status[4]);
      3'b110:  cond_base = ~cu.status[1] & (cu.status[2] == cu.status[4]);
      default: cond_base = 1'b1;
    endcase
    bcond_taken = (ir_q[3:0] == 4'b1111) ? 1'b1 : (cond_base ^ ir_q[0]);
  end
`else
  logic unused_flags;
  assign unused_flags = ^cu.status[4:1];
  assign bcond_taken  = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        ir_d    = cu.instruction;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (kind == K_NONE)      state_d = S_HALT;
        else if (kind == K_LDUR) state_d = S_MEM;
        else                     state_d = S_FETCH;
      end
      S_MEM:   state_d = S_FETCH;
      default: state_d = S_HALT;
    endcase
  end

  logic              en_pc, en_mem, en_alu, pc_sel, b_sel, sl, wm, wr;
  logic [1:0]        ps;
  logic [4:0]        fs, sb, sa, da;
  logic [DATA_W-1:0] const_v;

  always_comb begin
    en_pc = 1'b0; en_mem = 1'b0; en_alu = 1'b0; pc_sel = 1'b0;
    b_sel = 1'b0; sl = 1'b0; wm = 1'b0; wr = 1'b0;
    ps = 2'b00; fs = 5'b0; sb = 5'b0; sa = 5'b0; da = 5'b0;
    const_v = '0;
    if (state_q == S_EXEC) begin
      case (kind)
        K_RTYPE: begin
          sa = rn; sb = rm; da = rd; en_alu = 1'b1; wr = 1'b1; ps = 2'b01;
          fs = alu_fs; sl = alu_sl;
        end
        K_ITYPE: begin
          const_v = imm12_z; b_sel = 1'b1; sa = rn; da = rd;
          en_alu = 1'b1; wr = 1'b1; ps = 2'b01; fs = alu_fs;
        end
        K_STUR: begin
          const_v = imm9_s; sa = rn; sb = rd; b_sel = 1'b1; fs = 5'b01000;
          wm = 1'b1; ps = 2'b01;
        end
        K_LDUR: begin
          const_v = imm9_s; sa = rn; b_sel = 1'b1; fs = 5'b01000;
        end
        K_B: begin
          const_v = imm26_s; pc_sel = 1'b1; ps = 2'b11;
        end
        K_BL: begin
          const_v = imm26_s; pc_sel = 1'b1; ps = 2'b11;
          en_pc = 1'b1; wr = 1'b1; da = 5'd30;
        end
        K_BR: begin
          sa = rn; ps = 2'b10;
        end
        K_CBZ, K_CBNZ: begin
          const_v = imm19_s; sa = 5'd31; sb = rd; fs = 5'b00100; pc_sel = 1'b1;
          ps = (cu.status[0] == (kind == K_CBZ)) ? 2'b11 : 2'b01;
        end
        K_BCOND: begin
          const_v = imm19_s; pc_sel = 1'b1;
          ps = bcond_taken ? 2'b11 : 2'b01;
        end
        default: ;
      endcase
    end else if (state_q == S_MEM) begin
      const_v = imm9_s; sa = rn; b_sel = 1'b1; fs = 5'b01000;
      en_mem = 1'b1; wr = 1'b1; da = rd; ps = 2'b01;
    end
  end

  // Reset suppresses every enable so an interrupted LDUR never writes back.
  assign cu.control_word = reset ? '0 :
    {en_pc, en_mem, en_alu, pc_sel, b_sel, sl, wm, wr, ps, fs, sb, sa, da};
  assign cu.constant  = const_v;
  assign cu.halted    = (state_q == S_HALT);
  assign cu.state_dbg = state_q;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Directed bench for control_unit_fsm: mnemonic-level model feeding an expected queue,
// checked every cycle on the falling edge, plus hand-computed literal checks.
module tb_control_unit_fsm;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  control_unit_fsm_if #(.CW_W(30), .DATA_W(64)) cu ();
  control_unit_fsm #(.CW_W(30), .DATA_W(64)) dut (.clock(clock), .reset(reset), .cu(cu));

  int total = 0;
  int bad   = 0;
  logic [94:0] exp_q[$];

  localparam int M_NONE = 0, M_ADD = 1, M_SUB = 2, M_AND = 3, M_ORR = 4, M_EOR = 5,
                 M_ADDS = 6, M_SUBS = 7, M_ADDI = 8, M_SUBI = 9, M_STUR = 10, M_LDUR = 11,
                 M_B = 12, M_BL = 13, M_BR = 14, M_CBZ = 15, M_CBNZ = 16, M_BCOND = 17;
  localparam int PH_FETCH = 0, PH_EXEC = 1, PH_MEM = 2, PH_HALT = 3;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic int mnem(input logic [31:0] ir);
    int unsigned o11, o10, o8, o6;
    o11 = ir >> 21; o10 = ir >> 22; o8 = ir >> 24; o6 = ir >> 26;
    if (o11 == 'b10001011000) return M_ADD;
    if (o11 == 'b11001011000) return M_SUB;
    if (o11 == 'b10001010000) return M_AND;
    if (o11 == 'b10101010000) return M_ORR;
    if (o11 == 'b11001010000) return M_EOR;
    if (o11 == 'b10101011000) return M_ADDS;
    if (o11 == 'b11101011000) return M_SUBS;
    if (o11 == 'b11111000000) return M_STUR;
    if (o11 == 'b11111000010) return M_LDUR;
    if (o11 == 'b11010110000) return M_BR;
    if (o10 == 'b1001000100) return M_ADDI;
    if (o10 == 'b1101000100) return M_SUBI;
    if (o8 == 'b10110100) return M_CBZ;
    if (o8 == 'b10110101) return M_CBNZ;
`ifdef CU_BCOND_EN
    if (o8 == 'b01010100 && ir[4] == 1'b0) return M_BCOND;
`endif
    if (o6 == 'b000101) return M_B;
    if (o6 == 'b100101) return M_BL;
    return M_NONE;
  endfunction

  function automatic int alu_code(input int m);
    case (m)
      M_AND:                        return 0;
      M_ORR:                        return 4;
      M_EOR:                        return 12;
      M_SUB, M_SUBS, M_SUBI:        return 9;
      default:                      return 8;
    endcase
  endfunction

  function automatic longint sext(input longint raw, input int bits);
    longint v;
    v = raw & ((64'sd1 <<< bits) - 1);
    if (v >= (64'sd1 <<< (bits - 1))) v = v - (64'sd1 <<< bits);
    return v;
  endfunction

  function automatic bit cond_holds(input int c, input logic [4:0] st);
    bit v, cf, n, z;
    v = st[4]; cf = st[3]; n = st[2]; z = st[1];
    case (c)
      0:  return z;
      1:  return !z;
      2:  return cf;
      3:  return !cf;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return cf && !z;
      9:  return !(cf && !z);
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  // Returns {halted, control_word, constant} for one cycle of an instruction's life.
  function automatic logic [94:0] model(input logic [31:0] ir, input logic [4:0] st,
                                        input int ph, input bit in_reset);
    int en_pc = 0, en_mem = 0, en_alu = 0, pcsel = 0, bsel = 0, sl = 0, wm = 0, wr = 0;
    int ps = 0, fs = 0, sb = 0, sa = 0, da = 0;
    int rd, rn, rm, m;
    longint k = 0;
    longint w;
    bit h = 1'b0;
    rd = int'(ir[4:0]); rn = int'(ir[9:5]); rm = int'(ir[20:16]);
    m = mnem(ir);
    if (ph == PH_HALT) h = 1'b1;
    else if (ph == PH_EXEC || ph == PH_MEM) begin
      case (m)
        M_ADD, M_SUB, M_AND, M_ORR, M_EOR, M_ADDS, M_SUBS: begin
          sa = rn; sb = rm; da = rd; en_alu = 1; wr = 1; ps = 1; fs = alu_code(m);
          sl = (m == M_ADDS || m == M_SUBS) ? 1 : 0;
        end
        M_ADDI, M_SUBI: begin
          k = (ir >> 10) & 'hFFF; bsel = 1; sa = rn; da = rd; en_alu = 1; wr = 1; ps = 1;
          fs = alu_code(m);
        end
        M_STUR: begin k = sext(ir >> 12, 9); sa = rn; sb = rd; bsel = 1; fs = 8; wm = 1; ps = 1; end
        M_LDUR: begin
          k = sext(ir >> 12, 9); sa = rn; bsel = 1; fs = 8;
          if (ph == PH_MEM) begin en_mem = 1; wr = 1; da = rd; ps = 1; end
        end
        M_B, M_BL: begin
          k = sext(ir, 26); pcsel = 1; ps = 3;
          if (m == M_BL) begin en_pc = 1; wr = 1; da = 30; end
        end
        M_BR: begin sa = rn; ps = 2; end
        M_CBZ, M_CBNZ: begin
          k = sext(ir >> 5, 19); sa = 31; sb = rd; fs = 4; pcsel = 1;
          ps = ((st[0] == 1'b1) == (m == M_CBZ)) ? 3 : 1;
        end
        M_BCOND: begin
          k = sext(ir >> 5, 19); pcsel = 1;
          ps = cond_holds(int'(ir[3:0]), st) ? 3 : 1;
        end
        default: ;
      endcase
    end
    w = en_pc;
    w = w * 2 + en_mem; w = w * 2 + en_alu; w = w * 2 + pcsel; w = w * 2 + bsel;
    w = w * 2 + sl;     w = w * 2 + wm;     w = w * 2 + wr;    w = w * 4 + ps;
    w = w * 32 + fs;    w = w * 32 + sb;    w = w * 32 + sa;   w = w * 32 + da;
    if (in_reset) w = 0;
    return {h, 30'(w), 64'(k)};
  endfunction

  always @(negedge clock) begin
    logic [94:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cyc_halted", {63'd0, cu.halted}, {63'd0, e[94]});
      check("cyc_cw", {34'd0, cu.control_word}, {34'd0, e[93:64]});
      check("cyc_const", cu.constant, e[63:0]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic halt_and_recover(input string name);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(model(32'h0, 5'h0, PH_HALT, 1'b0));
      if (i == 0) begin
        #3;
        check({name, "_halted"}, {63'd0, cu.halted}, 64'd1);
      end
      step();
    end
    reset = 1'b1;
    exp_q.push_back(model(32'h0, 5'h0, PH_HALT, 1'b1));
    step();
    reset = 1'b0;
    #3;
    check({name, "_unhalt"}, {63'd0, cu.halted}, 64'd0);
  endtask

  task automatic run_instr(input logic [31:0] ir, input logic [4:0] st, input string name,
                           input bit lit, input logic [29:0] lit_cw, input logic [63:0] lit_k);
    cu.instruction = ir;
    cu.status      = st;
    exp_q.push_back(model(ir, st, PH_FETCH, 1'b0));
    step();
    exp_q.push_back(model(ir, st, PH_EXEC, 1'b0));
    if (lit) begin
      #3;
      check({name, "_cw"}, {34'd0, cu.control_word}, {34'd0, lit_cw});
      check({name, "_k"}, cu.constant, lit_k);
    end
    step();
    if (mnem(ir) == M_LDUR) begin
      exp_q.push_back(model(ir, st, PH_MEM, 1'b0));
      step();
    end
    if (mnem(ir) == M_NONE) halt_and_recover(name);
  endtask

  task automatic run_ldur(input bit rst_in_mem);
    logic [31:0] ir;
    ir = 32'hF84080A4;
    cu.instruction = ir;
    cu.status      = 5'h0;
    exp_q.push_back(model(ir, 5'h0, PH_FETCH, 1'b0));
    step();
    exp_q.push_back(model(ir, 5'h0, PH_EXEC, 1'b0));
    #3;
    check("ldur_exec_cw", {34'd0, cu.control_word}, {34'd0, 30'h0204_00A0});
    check("ldur_exec_k", cu.constant, 64'd8);
    step();
    if (rst_in_mem) begin
      reset = 1'b1;
      exp_q.push_back(model(ir, 5'h0, PH_MEM, 1'b1));
      #3;
      check("ldur_rst_wr", {63'd0, cu.control_word[22]}, 64'd0);
      check("ldur_rst_wm", {63'd0, cu.control_word[23]}, 64'd0);
      step();
      reset = 1'b0;
      #3;
      check("ldur_rst_fetch_cw", {34'd0, cu.control_word}, 64'd0);
    end else begin
      exp_q.push_back(model(ir, 5'h0, PH_MEM, 1'b0));
      #3;
      check("ldur_mem_cw", {34'd0, cu.control_word}, {34'd0, 30'h1254_00A4});
      step();
    end
  endtask

  initial begin
    cu.instruction = 32'h0;
    cu.status      = 5'h0;
    reset          = 1'b1;
    step();
    exp_q.push_back(model(32'h0, 5'h0, PH_FETCH, 1'b1));
    step();
    reset = 1'b0;
    #3;
    check("rst_cw", {34'd0, cu.control_word}, 64'd0);
    check("rst_k", cu.constant, 64'd0);
    check("rst_halted", {63'd0, cu.halted}, 64'd0);

    run_instr(32'h8B030041, 5'h0, "add", 1'b1, 30'h0854_0C41, 64'd0);
    run_instr(32'hAA030041, 5'h0, "orr", 1'b0, 30'h0, 64'd0);
    run_instr(32'hEB0700C5, 5'h0, "subs", 1'b0, 30'h0, 64'd0);
    run_instr(32'h913FFD49, 5'h0, "addi", 1'b0, 30'h0, 64'd0);
    run_instr(32'hF81F8041, 5'h0, "stur", 1'b0, 30'h0, 64'd0);
    run_instr(32'h17FFFFFF, 5'h0, "b", 1'b0, 30'h0, 64'd0);
    run_instr(32'h94000004, 5'h0, "bl", 1'b0, 30'h0, 64'd0);
    run_instr(32'hD60003C0, 5'h0, "br", 1'b0, 30'h0, 64'd0);
    run_instr(32'hB5FFFFC3, 5'h0, "cbnz", 1'b0, 30'h0, 64'd0);
    run_ldur(1'b0);
    run_ldur(1'b1);
    run_instr(32'hB4000067, 5'b00001, "cbz_taken", 1'b1, 30'h0432_1FE0, 64'd3);
    run_instr(32'hB4000067, 5'b00000, "cbz_not", 1'b1, 30'h0412_1FE0, 64'd3);
`ifdef CU_BCOND_EN
    run_instr(32'h5400004B, 5'b10000, "blt_taken", 1'b1, 30'h0430_0000, 64'd2);
    run_instr(32'h5400004B, 5'b00000, "blt_not", 1'b1, 30'h0410_0000, 64'd2);
`else
    run_instr(32'h5400004B, 5'b10000, "blt_halt", 1'b1, 30'h0, 64'd0);
`endif
    run_instr(32'h00000000, 5'h0, "zero", 1'b1, 30'h0, 64'd0);
    run_instr(32'h8B030041, 5'h0, "add_after", 1'b1, 30'h0854_0C41, 64'd0);

    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      bad++;
      total++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit_fsm.md
Name: control_unit_fsm

Overview:
Multi-cycle LEGv8 control unit. It is the producing end of the datapath's control-word interface. It latches the fetched instruction, decodes it, and drives the 30-bit control word and 64-bit constant that the datapath consumes. It steps through FETCH/EXECUTE/MEMORY states per instruction and reads the datapath status flags to resolve conditional branches.

Parameters:
- CW_W, 30, control word width (fixed field map below)
- DATA_W, 64, constant width

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- instruction  in  32  instruction from program ROM at current PC
- status  in  5  [4]=V, [3]=C, [2]=N, [1]=Z (registered flags); [0]=live ALU zero
- control_word  out  30  [29]EN_PC [28]EN_Mem [27]EN_ALU [26]PCsel [25]Bsel [24]SL [23]WM [22]WR [21:20]PS [19:15]FS [14:10]SB [9:5]SA [4:0]DA
- constant  out  64  extended immediate for the current instruction
- halted  out  1  high while in HALT

Behaviour:
- One clock, reset synchronous active-high.
- Reset: state←FETCH, IR←0. control_word=0, constant=0, halted=0 on the cycle after reset.
- Reset asserted mid-instruction (any state, including MEM or HALT): the next edge forces FETCH. No writes are issued in the reset cycle (WR=WM=0).
- Outputs are combinational from state and IR.
- PS encoding: 00 hold, 01 PC+4, 10 PC←A bus, 11 PC←PC+4·constant.
- FS encoding: {op[2:0], invA, invB/Cin}. AND=00000, ORR=00100, ADD=01000, SUB=01001, EOR=01100.
- FETCH: control_word=0. IR←instruction. Next state EXECUTE.
- EXECUTE, R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, EOR 11001010000, ADDS 10101011000, SUBS 11101011000):
  - SA=IR[9:5], SB=IR[20:16], DA=IR[4:0]
  - EN_ALU=1, WR=1, PS=01
  - SL=1 only for ADDS/SUBS
  - Next state FETCH.
- EXECUTE, I-type (ADDI 1001000100, SUBI 1101000100): constant=zero-extend IR[21:10]. Bsel=1. Otherwise as R-type.
- EXECUTE, STUR (11111000000): constant=sign-extend IR[20:12]. SA=Rn, SB=Rt, Bsel=1, FS=ADD, WM=1, PS=01. Next FETCH.
- LDUR (11111000010) takes two execute states:
  - EXECUTE: SA=Rn, Bsel=1, FS=ADD, PS=00, no enables. Next MEM.
  - MEM: same fields plus EN_Mem=1, WR=1, DA=Rt, PS=01. Next FETCH.
- B (000101): constant=sign-extend IR[25:0], PCsel=1, PS=11.
- BL (100101): as B, plus EN_PC=1, WR=1, DA=30.
- BR (11010110000): SA=Rn, PCsel=0, PS=10.
- CBZ (10110100) / CBNZ (10110101):
  - constant=sign-extend IR[23:5]
  - SA=31, SB=Rt, FS=ORR, PCsel=1
  - PS=11 if status[0] equals the taken condition (Z=1 for CBZ, Z=0 for CBNZ), else PS=01
  - Resolved in the same cycle.
- Unused register-select fields drive 0.
- Opcode matching is longest-prefix. Any unmatched opcode in EXECUTE → HALT.
- HALT: control_word=0, halted=1. Stays in HALT until reset.
- Latency: 2 cycles per instruction; 3 for LDUR.

Optional Feature:
- Macro: CU_BCOND_EN.
- Defined: B.cond (01010100, IR[4]=0) is decoded.
  - constant=sign-extend IR[23:5], PCsel=1.
  - Condition IR[3:0] is evaluated on status[4:1] with standard ARM semantics (EQ..LE, AL=1110 always taken).
  - PS=11 if taken, else 01.
- Undefined: opcode 01010100 is unmatched → HALT.

Test Plan:
- Reset held 2 cycles, then released → control_word=0, constant=0, halted=0. First edge latches the instruction; control_word=0 during FETCH.
- instruction=0x8B030041 (ADD X1,X2,X3) → EXECUTE: EN_ALU=1, WR=1, PS=01, FS=01000, SB=3, SA=2, DA=1, SL=0. Next cycle is FETCH.
- instruction=0xF84080A4 (LDUR X4,[X5,#8]):
  - EXECUTE: constant=8, SA=5, Bsel=1, FS=01000, PS=00, WR=0.
  - MEM: EN_Mem=1, WR=1, DA=4, PS=01.
  - Reset asserted in MEM → FETCH next edge, no WR.
- instruction=0xB4000067 (CBZ X7,+3), constant=3:
  - status[0]=1 → PS=11, PCsel=1, SB=7, SA=31.
  - Repeat with status[0]=0 → PS=01.
- instruction=0x00000000 → HALT: halted=1, control_word=0 for 10 cycles. Reset → FETCH, halted=0.
- With CU_BCOND_EN, instruction=0x5400004B (B.LT +2):
  - status[4:1]=1000 (V=1, N=0) → PS=11, constant=2.
  - status[4:1]=0000 → PS=01.
  - Without the macro → HALT.
